// File: rtl/xnn_pkg.sv
// rtl/xnn_pkg.sv - shared width, select codes and FSM state type for the decoder
package xnn_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SEL_XOR  = 2'b00,
    SEL_NOR  = 2'b01,
    SEL_NAND = 2'b10,
    SEL_NONE = 2'b11
  } sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/xnn_match.sv
// rtl/xnn_match.sv - combinational classifier of (a, b, res) against xor/nor/nand
module xnn_match
  import xnn_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] res,
  output sel_t              code,
  output logic              match,
  output logic              ambiguous
);

  logic hit_xor;
  logic hit_nor;
  logic hit_nand;

  assign hit_xor  = ((a ^ b) == res);
  assign hit_nor  = (~(a | b) == res);
  assign hit_nand = (~(a & b) == res);

  // Lowest code wins; ambiguity flags any pair of simultaneous hits
  always_comb begin
    code      = SEL_NONE;
    match     = hit_xor | hit_nor | hit_nand;
    ambiguous = (hit_xor & hit_nor) | (hit_xor & hit_nand) | (hit_nor & hit_nand);
    if (hit_xor) begin
      code = SEL_XOR;
    end else if (hit_nor) begin
      code = SEL_NOR;
    end else if (hit_nand) begin
      code = SEL_NAND;
    end
  end

endmodule

// File: rtl/xor_nor_nand_decoder.sv
// rtl/xor_nor_nand_decoder.sv - registered one-deep decoder recovering the select code of a logic op
module xor_nor_nand_decoder
  import xnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s1,
  output logic              s0,
  output logic              match,
  output logic              ambiguous,
  output logic [7:0]        mismatch_count
);

  state_t state;
  state_t state_next;

  sel_t   code_c;
  logic   match_c;
  logic   ambiguous_c;

  sel_t   code_q;
  logic   match_q;
  logic   ambiguous_q;
  logic   accept;

  xnn_match u_match (
    .a         (a),
    .b         (b),
    .res       (res),
    .code      (code_c),
    .match     (match_c),
    .ambiguous (ambiguous_c)
  );

  // Ready depends only on the held state and downstream, never on in_valid
  assign in_ready = (state == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // State register; reset discards any held result
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a new accept always refills, otherwise drain on out_ready
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL: begin
        if (accept) begin
          state_next = ST_FULL;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Output decode of the FSM
  always_comb begin
    out_valid = (state == ST_FULL);
  end

  // Result register loads only on accept so a stalled result stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q      <= SEL_XOR;
      match_q     <= 1'b0;
      ambiguous_q <= 1'b0;
    end else if (accept) begin
      code_q      <= code_c;
      match_q     <= match_c;
      ambiguous_q <= ambiguous_c;
    end
  end

  // Saturating count of accepted triples that no operation reproduces
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_count <= 8'd0;
    end else if (accept && !match_c && (mismatch_count != 8'hFF)) begin
      mismatch_count <= mismatch_count + 8'd1;
    end
  end

  assign s1        = code_q[1];
  assign s0        = code_q[0];
  assign match     = match_q;
  assign ambiguous = ambiguous_q;

endmodule

// File: tb/tb_xor_nor_nand_decoder.sv
// tb/tb_xor_nor_nand_decoder.sv - directed self-checking bench for xor_nor_nand_decoder
module tb_xor_nor_nand_decoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] res;
  logic       out_valid;
  logic       out_ready;
  logic       s1;
  logic       s0;
  logic       match;
  logic       ambiguous;
  logic [7:0] mismatch_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  xor_nor_nand_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .res            (res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .s1             (s1),
    .s0             (s0),
    .match          (match),
    .ambiguous      (ambiguous),
    .mismatch_count (mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values and ready in the first cycle after release
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00; res = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({out_valid, s1, s0, match, ambiguous} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000", {out_valid, s1, s0, match, ambiguous});
    end
    checks++;
    if (mismatch_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d expected 0", mismatch_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    exp_cnt = 0;
  endtask

  // One isolated triple per vector, result checked one cycle after accept
  task automatic test_single(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] vr, input logic [1:0] ecode,
                             input logic emat, input logic eamb);
    @(negedge clk);
    a = va; b = vb; res = vr; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready got %b expected 1", name, in_ready);
    end
    if (!emat) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, s1, s0, match, ambiguous} !== {1'b1, ecode, emat, eamb}) begin
      errors++;
      $display("FAIL %s got v=%b code=%b m=%b amb=%b expected v=1 code=%b m=%b amb=%b",
               name, out_valid, {s1, s0}, match, ambiguous, ecode, emat, eamb);
    end
    checks++;
    if (mismatch_count !== exp_cnt[7:0]) begin
      errors++;
      $display("FAIL %s_count got %0d expected %0d", name, mismatch_count, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got out_valid=%b expected 0", name, out_valid);
    end
  endtask

  // Continuous stream with out_ready=1: out_valid must never drop
  task automatic test_back_to_back();
    logic [7:0] vres [3];
    logic [1:0] vcode [3];
    vres[0] = 8'hCC; vres[1] = 8'h12; vres[2] = 8'hDE;
    vcode[0] = 2'b00; vcode[1] = 2'b01; vcode[2] = 2'b10;
    out_ready = 1'b1;
    a = 8'h69; b = 8'hA5;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({out_valid, s1, s0, match, ambiguous} !== {1'b1, vcode[i-1], 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL b2b_%0d got v=%b code=%b m=%b amb=%b expected v=1 code=%b m=1 amb=0",
                   i - 1, out_valid, {s1, s0}, match, ambiguous, vcode[i-1]);
        end
      end
      if (i < 3) begin
        res = vres[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Unmatched triples: code 11, count steps and saturates at 255
  task automatic test_mismatch();
    test_single("nomatch", 8'h77, 8'h0B, 8'h00, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h77; b = 8'h0B; res = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 299; i++) begin
      @(negedge clk);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 253) begin
        checks++;
        if (mismatch_count !== 8'd255) begin
          errors++;
          $display("FAIL sat_reach got %0d expected 255", mismatch_count);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (mismatch_count !== 8'd255 || exp_cnt != 255) begin
      errors++;
      $display("FAIL sat_hold got %0d expected 255", mismatch_count);
    end
    @(negedge clk);
  endtask

  // Downstream stall holds the result; release consumes and accepts in one edge
  task automatic test_stall();
    @(negedge clk);
    a = 8'h77; b = 8'h0B; res = 8'h7C; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    res = 8'h80;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, s1, s0, match, ambiguous} !== 6'b010010) begin
        errors++;
        $display("FAIL stall_%0d got rdy=%b v=%b code=%b m=%b amb=%b expected rdy=0 v=1 code=00 m=1 amb=0",
                 i, in_ready, out_valid, {s1, s0}, match, ambiguous);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, s1, s0, match} !== 4'b1011) begin
      errors++;
      $display("FAIL release_next got v=%b code=%b m=%b expected v=1 code=01 m=1",
               out_valid, {s1, s0}, match);
    end
    @(negedge clk);
  endtask

  // Reset while FULL, with a triple offered during the reset cycle
  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'h77; b = 8'h0B; res = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1; res = 8'h7C;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, in_ready, match} !== 3'b010 || mismatch_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got v=%b rdy=%b m=%b cnt=%0d expected v=0 rdy=1 m=0 cnt=0",
               out_valid, in_ready, match, mismatch_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got out_valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single("xor", 8'h77, 8'h0B, 8'h7C, 2'b00, 1'b1, 1'b0);
    test_single("nor", 8'h77, 8'h0B, 8'h80, 2'b01, 1'b1, 1'b0);
    test_single("nand", 8'h77, 8'h0B, 8'hFC, 2'b10, 1'b1, 1'b0);
    test_back_to_back();
    test_single("amb_ff", 8'hFF, 8'hFF, 8'h00, 2'b00, 1'b1, 1'b1);
    test_single("amb_3c", 8'h3C, 8'h3C, 8'hC3, 2'b01, 1'b1, 1'b1);
    test_mismatch();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
